// File: rtl/alu_acc_seq.sv
// Accumulator command sequencer in front of an external combinational 8-bit ALU.
// Commands queue in a small FIFO, run one at a time through IDLE/EXEC/RESP, and results return on a valid/ready port.
module alu_acc_seq #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [7:0]       cmd_data,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       fifo_data_q [DEPTH];
  logic [2:0]       fifo_op_q   [DEPTH];
  logic             fifo_load_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       opnd_data_q, opnd_data_d;
  logic [2:0]       opnd_op_q, opnd_op_d;
  logic             opnd_load_q, opnd_load_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             push_s, pop_s, empty_s, full_s;

  assign empty_s = (level_q == {LVL_W{1'b0}});
  assign full_s  = (level_q == LVL_FULL);
  // cmd_ready depends only on the level register, so a pop never frees a slot in the same cycle
  assign push_s  = cmd_valid && !full_s;

  // FIFO pointer and level next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= 8'h00;
        fifo_op_q[i]   <= 3'b000;
        fifo_load_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      fifo_data_q[wr_ptr_q] <= cmd_data;
      fifo_op_q[wr_ptr_q]   <= cmd_op;
      fifo_load_q[wr_ptr_q] <= cmd_load;
    end
  end

  // Sequencer next-state: pop in IDLE, capture ALU in EXEC, hold result in RESP
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    acc_d       = acc_q;
    opnd_data_d = opnd_data_q;
    opnd_op_d   = opnd_op_q;
    opnd_load_d = opnd_load_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          opnd_data_d = fifo_data_q[rd_ptr_q];
          opnd_op_d   = fifo_op_q[rd_ptr_q];
          opnd_load_d = fifo_load_q[rd_ptr_q];
          state_d     = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (opnd_load_q) begin
          acc_d   = opnd_data_q;
          carry_d = 1'b0;
          zero_d  = (opnd_data_q == 8'h00);
        end else begin
          acc_d   = alu_y;
          carry_d = alu_carry;
          zero_d  = alu_zero;
        end
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer, pointer and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      acc_q       <= 8'h00;
      opnd_data_q <= 8'h00;
      opnd_op_q   <= 3'b000;
      opnd_load_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      opnd_data_q <= opnd_data_d;
      opnd_op_q   <= opnd_op_d;
      opnd_load_q <= opnd_load_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign cmd_ready  = !full_s;
  assign alu_a      = acc_q;
  assign alu_b      = opnd_data_q;
  assign alu_op     = opnd_op_q;
  assign res_valid  = (state_q == RESP);
  assign res_data   = acc_q;
  assign res_carry  = carry_q;
  assign res_zero   = zero_q;
  assign busy       = (state_q != IDLE) || !empty_s;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq with a behavioural 8-bit ALU on the alu_* ports.
module tb_alu_acc_seq;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_load;
  logic [7:0] cmd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       alu_zero;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       busy;
  logic [2:0] fifo_level;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  alu_acc_seq #(.DEPTH(4), .LVL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero),
    .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: SHL/SHR move one bit, carry takes the bit shifted out
  always_comb begin
    logic [8:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_y     = 8'h00;
    alu_carry = 1'b0;
    case (alu_op)
      3'd0: begin alu_y = sum[7:0]; alu_carry = sum[8]; end
      3'd1: begin alu_y = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'd2: alu_y = alu_a & alu_b;
      3'd3: alu_y = alu_a | alu_b;
      3'd4: alu_y = alu_a ^ alu_b;
      3'd5: alu_y = ~alu_a;
      3'd6: begin alu_y = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      3'd7: begin alu_y = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
      default: alu_y = 8'h00;
    endcase
    alu_zero = (alu_y == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ld, input logic [2:0] op, input logic [7:0] d);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    check("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get(input string tag, input logic [7:0] ed, input logic ec, input logic ez);
    int w;
    w = 0;
    res_ready = 1'b1;
    while (!res_valid && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_data"},  {24'd0, res_data},  {24'd0, ed});
    check({tag, "_carry"}, {31'd0, res_carry}, {31'd0, ec});
    check({tag, "_zero"},  {31'd0, res_zero},  {31'd0, ez});
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int acc_cnt;
    logic [7:0] sum;
    logic [7:0] vd [5];
    logic [2:0] vo [5];
    logic       vl [5];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_load = 1'b0;
    cmd_data = 8'h00; res_ready = 1'b0;
    #2;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_acc", {24'd0, res_data}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_flags", {30'd0, res_carry, res_zero}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: load then ADD, with latency and operand checks
    send(1'b1, 3'd0, 8'h7F);
    lat = 0;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("t1_latency", lat, 32'd2);
    get("t1_load", 8'h7F, 1'b0, 1'b0);
    send(1'b0, 3'd0, 8'h01);
    tick();
    check("t1_exec_alu_a", {24'd0, alu_a}, 32'h7F);
    check("t1_exec_alu_b", {24'd0, alu_b}, 32'h01);
    check("t1_exec_alu_op", {29'd0, alu_op}, 32'd0);
    check("t1_exec_busy", {31'd0, busy}, 32'd1);
    get("t1_add", 8'h80, 1'b0, 1'b0);

    // 2: ADD overflow then SUB borrow
    send(1'b0, 3'd0, 8'h80);
    get("t2_add", 8'h00, 1'b1, 1'b1);
    send(1'b0, 3'd1, 8'h01);
    get("t2_sub", 8'hFF, 1'b1, 1'b0);

    // 3: logic ops and shifts
    send(1'b1, 3'd0, 8'hF0); get("t3_load", 8'hF0, 1'b0, 1'b0);
    send(1'b0, 3'd2, 8'h3C); get("t3_and", 8'h30, 1'b0, 1'b0);
    send(1'b0, 3'd4, 8'h30); get("t3_xor", 8'h00, 1'b0, 1'b1);
    send(1'b0, 3'd5, 8'h00); get("t3_not", 8'hFF, 1'b0, 1'b0);
    send(1'b0, 3'd7, 8'h00); get("t3_shr", 8'h7F, 1'b1, 1'b0);
    send(1'b0, 3'd6, 8'h00); get("t3_shl", 8'hFE, 1'b0, 1'b0);

    // 4: backpressure, continuous cmd_valid
    vl[0] = 1'b1; vo[0] = 3'd0; vd[0] = 8'h01;
    vl[1] = 1'b0; vo[1] = 3'd0; vd[1] = 8'h01;
    vl[2] = 1'b0; vo[2] = 3'd0; vd[2] = 8'h01;
    vl[3] = 1'b0; vo[3] = 3'd0; vd[3] = 8'h02;
    vl[4] = 1'b0; vo[4] = 3'd1; vd[4] = 8'h05;
    acc_cnt = 0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cmd_load = vl[(acc_cnt < 5) ? acc_cnt : 4];
      cmd_op   = vo[(acc_cnt < 5) ? acc_cnt : 4];
      cmd_data = vd[(acc_cnt < 5) ? acc_cnt : 4];
      if (cmd_ready) acc_cnt++;
      tick();
    end
    check("t4_accepted", acc_cnt, 32'd5);
    check("t4_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("t4_level", {29'd0, fifo_level}, 32'd4);
    cmd_valid = 1'b0;
    get("t4_r0", 8'h01, 1'b0, 1'b0);
    get("t4_r1", 8'h02, 1'b0, 1'b0);
    get("t4_r2", 8'h03, 1'b0, 1'b0);
    get("t4_r3", 8'h05, 1'b0, 1'b0);
    get("t4_r4", 8'h00, 1'b0, 1'b1);

    // 5: push and pop in the same cycle at level 2, then pointer wrap
    send(1'b0, 3'd0, 8'h10);
    send(1'b0, 3'd0, 8'h20);
    send(1'b0, 3'd4, 8'hFF);
    check("t5_res_valid", {31'd0, res_valid}, 32'd1);
    check("t5_first", {24'd0, res_data}, 32'h10);
    check("t5_level_pre", {29'd0, fifo_level}, 32'd2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t5_level_idle", {29'd0, fifo_level}, 32'd2);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd1; cmd_data = 8'h0F;
    tick();
    cmd_valid = 1'b0;
    check("t5_level_pushpop", {29'd0, fifo_level}, 32'd2);
    get("t5_b", 8'h30, 1'b0, 1'b0);
    get("t5_c", 8'hCF, 1'b0, 1'b0);
    get("t5_d", 8'hC0, 1'b0, 1'b0);
    send(1'b1, 3'd0, 8'h00);
    get("t5_clr", 8'h00, 1'b0, 1'b1);
    sum = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      send(1'b0, 3'd0, 8'(i));
      sum = sum + 8'(i);
      get("t5_wrap", sum, 1'b0, 1'b0);
    end

    // 6: reset during EXEC with 3 commands still queued
    send(1'b1, 3'd0, 8'h55);
    for (int i = 0; i < 4; i++) send(1'b0, 3'd0, 8'h01);
    check("t6_level_full", {29'd0, fifo_level}, 32'd4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("t6_level_exec", {29'd0, fifo_level}, 32'd3);
    check("t6_exec_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, res_valid}, 32'd0);
    check("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    check("t6_rst_acc", {24'd0, res_data}, 32'd0);
    check("t6_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    check("t6_post_valid", {31'd0, res_valid}, 32'd0);
    check("t6_post_busy", {31'd0, busy}, 32'd0);
    send(1'b1, 3'd0, 8'h11);
    get("t6_load", 8'h11, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
